alu: RTL and testbench
======================

# alu

8-bit registered arithmetic/logic unit for the datapath: two 8-bit operands and a 4-bit operation select in, an 8-bit result plus carry/borrow and zero flags out. All outputs are registered on the single system clock. Downstream register-file and branch logic consume them one cycle after the operands and select are presented.

## Interface
- No parameters; data width is fixed at 8 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high; sampled on rising clk.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- ALU_Sel  input  4  operation select; encoding below.
- ALU_Out  output  8  registered result.
- CarryOut  output  1  registered carry/borrow/shifted-out bit.
- Z  output  1  registered zero flag; 1 when the registered ALU_Out is 8'h00.

## Operation
- Opcode map (result R, carry C; C=0 unless stated):
  - 0000 PASS: R=A.
  - 0001 ADD: {C,R} = A+B (9-bit sum; C = bit 8).
  - 0010 SUB: R = (A−B) mod 256; C=1 (borrow) iff A<B unsigned.
  - 0011 NOR: R = ~(A|B).
  - 0100 AND: R = A&B.
  - 0101 OR: R = A|B.
  - 0110 EQ: R = 8'h01 if A==B, else 8'h00.
  - 0111 XOR: R = A^B.
  - 1000 LT: R = 8'h01 if A<B unsigned, else 8'h00.
  - 1001 GT: R = 8'h01 if A>B unsigned, else 8'h00.
  - 1010 NOT: R = ~A.
  - 1011 SHL: R = {A[6:0],1'b0}; C = A[7].
  - 1100 SHR, logical: R = {1'b0,A[7:1]}; C = A[0].
  - 1101 ROL: R = {A[6:0],A[7]}; C = A[7].
  - 1110 ROR: R = {A[0],A[7:1]}; C = A[0].
  - 1111 INC: {C,R} = A+1.
- B is ignored by PASS, NOT, the shifts, the rotates and INC.
- Z = (R==8'h00), computed from the result being registered, for every opcode.
- All comparisons are unsigned. There is no signed-overflow flag.
- The datapath is purely combinational into a single output register stage. There is no other internal state.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on ALU_Out/CarryOut/Z after edge N and hold until edge N+1.
- A new operation is accepted every cycle. There is no handshake and no stall.
- Reset values: ALU_Out=8'h00, CarryOut=0, Z=1.
- If rst is high at an edge, the reset values load regardless of A/B/ALU_Sel. Reset has priority over any operation.
- The first valid result appears one edge after rst deasserts.
- Wrap-around: ADD, SUB and INC results are mod 256. 8'hFF+8'h01 gives R=00, C=1, Z=1.
- Outputs never change between clock edges, even if the inputs change.

## Test plan
- Reset: hold rst=1 for 2 cycles with A=8'hFF, B=8'h01, ALU_Sel=0001 → ALU_Out=00, CarryOut=0, Z=1. Release rst → next edge gives ALU_Out=00, CarryOut=1, Z=1.
- Arithmetic:
  - ADD 15+10 → 25, C=0, Z=0.
  - ADD 200+100 → 44, C=1.
  - SUB 20−25 → 251 (8'hFB), C=1, Z=0.
  - SUB 30−30 → 0, C=0, Z=1.
  - INC 8'hFF → 00, C=1, Z=1.
- Logic:
  - NOR 8'hAA,8'h55 → 8'h00, Z=1.
  - AND 8'hF0,8'h3C → 8'h30.
  - OR 8'hF0,8'h0F → 8'hFF.
  - XOR 8'hFF,8'hFF → 00, Z=1.
  - NOT 8'h0F → 8'hF0.
  - PASS 8'h5A → 8'h5A.
- Shifts/rotates:
  - SHL 8'h0F → 8'h1E, C=0.
  - SHL 8'h80 → 00, C=1, Z=1.
  - SHR 8'hF0 → 8'h78, C=0.
  - ROL 8'h81 → 8'h03, C=1.
  - ROR 8'h01 → 8'h80, C=1.
- Compare:
  - LT 10,20 → 8'h01, Z=0.
  - LT 20,10 → 00, Z=1.
  - EQ 30,30 → 8'h01.
  - GT 8'h80,8'h7F → 8'h01 (unsigned).
- Back-to-back: change ALU_Sel every cycle across all 16 opcodes. Each result appears exactly one edge after its inputs, with no bubbles. Assert rst mid-sequence → outputs go to reset values on that edge.

Source files
------------

// File: rtl/alu.sv
// alu: 8-bit arithmetic/logic unit with a single registered output stage.
// Operands and select are decoded combinationally; result, carry/borrow
// and zero flag are captured together on the rising edge of clk, so the
// downstream consumers see all three outputs change on the same edge.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic       CarryOut,
    output logic       Z
);

    typedef enum logic [3:0] {
        OP_PASS = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_NOR  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_EQ   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_LT   = 4'b1000,
        OP_GT   = 4'b1001,
        OP_NOT  = 4'b1010,
        OP_SHL  = 4'b1011,
        OP_SHR  = 4'b1100,
        OP_ROL  = 4'b1101,
        OP_ROR  = 4'b1110,
        OP_INC  = 4'b1111
    } op_e;

    op_e        op;
    logic [8:0] sum_ab;
    logic [8:0] diff_ab;
    logic [8:0] inc_a;
    logic [7:0] result;
    logic       carry;

    assign op = op_e'(ALU_Sel);

    // Shared 9-bit adders; bit 8 is the carry (ADD/INC) or the borrow (SUB).
    assign sum_ab  = {1'b0, A} + {1'b0, B};
    assign diff_ab = {1'b0, A} - {1'b0, B};
    assign inc_a   = {1'b0, A} + 9'd1;

    // Operation decode: result and carry for the selected opcode.
    always_comb begin
        result = 8'h00;
        carry  = 1'b0;
        unique case (op)
            OP_PASS: result = A;
            OP_ADD:  {carry, result} = sum_ab;
            OP_SUB:  {carry, result} = diff_ab;
            OP_NOR:  result = ~(A | B);
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_EQ:   result = {7'd0, (A == B)};
            OP_XOR:  result = A ^ B;
            OP_LT:   result = {7'd0, (A < B)};
            OP_GT:   result = {7'd0, (A > B)};
            OP_NOT:  result = ~A;
            OP_SHL: begin
                result = {A[6:0], 1'b0};
                carry  = A[7];
            end
            OP_SHR: begin
                result = {1'b0, A[7:1]};
                carry  = A[0];
            end
            OP_ROL: begin
                result = {A[6:0], A[7]};
                carry  = A[7];
            end
            OP_ROR: begin
                result = {A[0], A[7:1]};
                carry  = A[0];
            end
            OP_INC:  {carry, result} = inc_a;
            default: begin
                result = 8'h00;
                carry  = 1'b0;
            end
        endcase
    end

    // Output register; reset wins over any operation, and Z is derived
    // from the value being loaded so it always matches ALU_Out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Out  <= 8'h00;
            CarryOut <= 1'b0;
            Z        <= 1'b1;
        end else begin
            ALU_Out  <= result;
            CarryOut <= carry;
            Z        <= (result == 8'h00);
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of the registered ALU against a
// plain-arithmetic reference model.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic       CarryOut;
    logic       Z;

    int total;
    int bad;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
    } vec_t;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out),
        .CarryOut (CarryOut),
        .Z        (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the opcode table using integer arithmetic.
    // Returns {carry, result}.
    function automatic logic [8:0] ref_op(input int sel, input int a, input int b);
        int r;
        int c;
        logic [8:0] packed_rc;
        r = 0;
        c = 0;
        case (sel)
            0:  r = a;
            1:  begin r = (a + b) % 256; c = (a + b) / 256; end
            2:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            3:  r = 255 - (a | b);
            4:  r = a & b;
            5:  r = a | b;
            6:  r = (a == b) ? 1 : 0;
            7:  r = a ^ b;
            8:  r = (a < b) ? 1 : 0;
            9:  r = (a > b) ? 1 : 0;
            10: r = 255 - a;
            11: begin r = (a * 2) % 256; c = a / 128; end
            12: begin r = a / 2; c = a % 2; end
            13: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
            14: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
            default: begin r = (a + 1) % 256; c = (a + 1) / 256; end
        endcase
        packed_rc = {c[0], r[7:0]};
        return packed_rc;
    endfunction

    task automatic drive(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        ALU_Sel = sel;
        A       = a;
        B       = b;
    endtask

    task automatic test_reset();
        drive(4'b0001, 8'hFF, 8'h01);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (ALU_Out !== 8'h00 || CarryOut !== 1'b0 || Z !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: got out=%h c=%b z=%b, want out=00 c=0 z=1",
                         i, ALU_Out, CarryOut, Z);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ALU_Out !== 8'h00 || CarryOut !== 1'b1 || Z !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got out=%h c=%b z=%b, want out=00 c=1 z=1",
                     ALU_Out, CarryOut, Z);
        end
    endtask

    task automatic test_arith();
        vec_t v[5];
        v = '{'{4'b0001, 8'd15,  8'd10,  8'd25,  1'b0},
              '{4'b0001, 8'd200, 8'd100, 8'd44,  1'b1},
              '{4'b0010, 8'd20,  8'd25,  8'hFB,  1'b1},
              '{4'b0010, 8'd30,  8'd30,  8'h00,  1'b0},
              '{4'b1111, 8'hFF,  8'h00,  8'h00,  1'b1}};
        foreach (v[i]) begin
            drive(v[i].sel, v[i].a, v[i].b);
            @(posedge clk); #1;
            total++;
            if (ALU_Out !== v[i].r || CarryOut !== v[i].c || Z !== (v[i].r == 8'h00)) begin
                bad++;
                $display("FAIL arith[%0d] sel=%b a=%h b=%h: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
                         i, v[i].sel, v[i].a, v[i].b, ALU_Out, CarryOut, Z,
                         v[i].r, v[i].c, (v[i].r == 8'h00));
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[6];
        v = '{'{4'b0011, 8'hAA, 8'h55, 8'h00, 1'b0},
              '{4'b0100, 8'hF0, 8'h3C, 8'h30, 1'b0},
              '{4'b0101, 8'hF0, 8'h0F, 8'hFF, 1'b0},
              '{4'b0111, 8'hFF, 8'hFF, 8'h00, 1'b0},
              '{4'b1010, 8'h0F, 8'hC3, 8'hF0, 1'b0},
              '{4'b0000, 8'h5A, 8'hA5, 8'h5A, 1'b0}};
        foreach (v[i]) begin
            drive(v[i].sel, v[i].a, v[i].b);
            @(posedge clk); #1;
            total++;
            if (ALU_Out !== v[i].r || CarryOut !== v[i].c || Z !== (v[i].r == 8'h00)) begin
                bad++;
                $display("FAIL logic[%0d] sel=%b a=%h b=%h: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
                         i, v[i].sel, v[i].a, v[i].b, ALU_Out, CarryOut, Z,
                         v[i].r, v[i].c, (v[i].r == 8'h00));
            end
        end
    endtask

    task automatic test_shift_rot();
        vec_t v[5];
        v = '{'{4'b1011, 8'h0F, 8'hFF, 8'h1E, 1'b0},
              '{4'b1011, 8'h80, 8'hFF, 8'h00, 1'b1},
              '{4'b1100, 8'hF0, 8'hFF, 8'h78, 1'b0},
              '{4'b1101, 8'h81, 8'hFF, 8'h03, 1'b1},
              '{4'b1110, 8'h01, 8'hFF, 8'h80, 1'b1}};
        foreach (v[i]) begin
            drive(v[i].sel, v[i].a, v[i].b);
            @(posedge clk); #1;
            total++;
            if (ALU_Out !== v[i].r || CarryOut !== v[i].c || Z !== (v[i].r == 8'h00)) begin
                bad++;
                $display("FAIL shift[%0d] sel=%b a=%h: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
                         i, v[i].sel, v[i].a, ALU_Out, CarryOut, Z,
                         v[i].r, v[i].c, (v[i].r == 8'h00));
            end
        end
    endtask

    task automatic test_compare();
        vec_t v[5];
        v = '{'{4'b1000, 8'd10,  8'd20,  8'h01, 1'b0},
              '{4'b1000, 8'd20,  8'd10,  8'h00, 1'b0},
              '{4'b0110, 8'd30,  8'd30,  8'h01, 1'b0},
              '{4'b1001, 8'h80,  8'h7F,  8'h01, 1'b0},
              '{4'b0110, 8'd30,  8'd31,  8'h00, 1'b0}};
        foreach (v[i]) begin
            drive(v[i].sel, v[i].a, v[i].b);
            @(posedge clk); #1;
            total++;
            if (ALU_Out !== v[i].r || CarryOut !== v[i].c || Z !== (v[i].r == 8'h00)) begin
                bad++;
                $display("FAIL compare[%0d] sel=%b a=%h b=%h: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
                         i, v[i].sel, v[i].a, v[i].b, ALU_Out, CarryOut, Z,
                         v[i].r, v[i].c, (v[i].r == 8'h00));
            end
        end
    endtask

    task automatic test_hold();
        logic [8:0] exp;
        drive(4'b0001, 8'd100, 8'd27);
        exp = ref_op(1, 100, 27);
        @(posedge clk); #1;
        drive(4'b1010, 8'h00, 8'h00);
        #3;
        total++;
        if (ALU_Out !== exp[7:0] || CarryOut !== exp[8] || Z !== (exp[7:0] == 8'h00)) begin
            bad++;
            $display("FAIL hold_between_edges: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
                     ALU_Out, CarryOut, Z, exp[7:0], exp[8], (exp[7:0] == 8'h00));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [8:0] exp;
        int sel, a, b;
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 15);
            a   = (i % 10 == 0) ? 255 : $urandom_range(0, 255);
            b   = (i % 7 == 0) ? a : $urandom_range(0, 255);
            drive(sel[3:0], a[7:0], b[7:0]);
            exp = ref_op(sel, a, b);
            @(posedge clk); #1;
            total++;
            if (ALU_Out !== exp[7:0] || CarryOut !== exp[8] || Z !== (exp[7:0] == 8'h00)) begin
                bad++;
                $display("FAIL random[%0d] sel=%0d a=%h b=%h: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
                         i, sel, a[7:0], b[7:0], ALU_Out, CarryOut, Z,
                         exp[7:0], exp[8], (exp[7:0] == 8'h00));
            end
        end
    endtask

    // All 16 opcodes issued on consecutive edges; a reset is forced on the
    // edge at step 9 and the stream resumes right after it.
    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        logic [8:0] exp;
        logic       rst_q[$];
        logic       was_rst;
        int a, b;
        for (int pass = 0; pass < 2; pass++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            drive(4'd0, a[7:0], b[7:0]);
            rst = 1'b0;
            exp_q.push_back(ref_op(0, a, b));
            rst_q.push_back(1'b0);
            for (int i = 0; i < 16; i++) begin
                @(posedge clk); #1;
                exp     = exp_q.pop_front();
                was_rst = rst_q.pop_front();
                total++;
                if (was_rst) begin
                    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0 || Z !== 1'b1) begin
                        bad++;
                        $display("FAIL b2b_reset pass%0d step%0d: got out=%h c=%b z=%b, want out=00 c=0 z=1",
                                 pass, i, ALU_Out, CarryOut, Z);
                    end
                end else if (ALU_Out !== exp[7:0] || CarryOut !== exp[8] || Z !== (exp[7:0] == 8'h00)) begin
                    bad++;
                    $display("FAIL b2b pass%0d step%0d: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
                             pass, i, ALU_Out, CarryOut, Z, exp[7:0], exp[8], (exp[7:0] == 8'h00));
                end
                if (i < 15) begin
                    a = $urandom_range(0, 255);
                    b = $urandom_range(0, 255);
                    drive(4'(i + 1), a[7:0], b[7:0]);
                    rst = (pass == 1 && i + 1 == 9);
                    exp_q.push_back(ref_op(i + 1, a, b));
                    rst_q.push_back(rst);
                end
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(4'd0, 8'd0, 8'd0);
        test_reset();
        test_arith();
        test_logic();
        test_shift_rot();
        test_compare();
        test_hold();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
